window_serializer: RTL and testbench
====================================

# window_serializer

Parallel-to-stream converter for the sliding-window datapath. It accepts a complete window of `WINDOW_SIZE` samples in parallel, matching the `window_gen` output format. It then emits the samples one per handshake on a valid/ready stream feeding `temporal_conv` or any downstream streaming stage. A two-slot buffer (active + pending) lets the next window load while the current one drains, so back-to-back windows stream without bubbles.

## Interface
Parameters:
- `DATA_W`, 16: sample width in bits.
- `WINDOW_SIZE`, 32: samples per window; must be ≥ 2.
- `IDX_W`, `$clog2(WINDOW_SIZE)`: index width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `win_valid`  in  1  parallel window offered.
- `win_ready`  out  1  pending slot free; a window is accepted when `win_valid && win_ready`.
- `win_data[0:WINDOW_SIZE-1]`  in  `DATA_W` each  window samples; index 0 is the oldest.
- `win_reverse`  in  1  emission order, sampled with the window: 0 = index 0 up to `WINDOW_SIZE-1`, 1 = `WINDOW_SIZE-1` down to 0.
- `out_valid`  out  1  sample available.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_data`  out  `DATA_W`  current sample.
- `out_idx`  out  `IDX_W`  window index of `out_data`.
- `out_first`  out  1  first sample of a window.
- `out_last`  out  1  final sample of a window.
- `busy`  out  1  active or pending slot occupied.

## Operation
- Storage: active buffer (`WINDOW_SIZE`×`DATA_W` + reverse flag) and pending buffer (same), plus `pend_full`, position counter `pos` (0..`WINDOW_SIZE-1`) and state.
- States:
  - IDLE: active slot empty.
  - STREAM: active slot holds a window being emitted.
- `win_ready = !pend_full`. The signal is combinational from registers only, with no path from `win_valid`.
- Window accept, with `done` = last transfer this cycle (`out_valid && out_ready && out_last`):
  - IDLE → load active, `pos`=0, go to STREAM.
  - STREAM, `pend_full`=0, `done`=1 → load directly into active, `pos`=0, stay in STREAM.
  - STREAM otherwise → load pending, set `pend_full`.
- Per transfer in STREAM: `pos`+1. On `done`:
  - If `pend_full`, promote pending → active, clear `pend_full`, `pos`=0, stay in STREAM.
  - Else if a window is accepted this cycle, follow the accept rule above.
  - Else go to IDLE.
- When `done`, `pend_full`=1 and `win_valid`=1 in the same cycle, `win_ready` is 0, so no accept occurs. The pending window is promoted and the offered window is accepted next cycle.
- Index mapping: `out_idx = reverse ? WINDOW_SIZE-1-pos : pos`. `out_data = active[out_idx]`.
- `out_first = out_valid && pos==0`. `out_last = out_valid && pos==WINDOW_SIZE-1`.
- `out_valid` = (state==STREAM). `busy = (state==STREAM) || pend_full`.
- Samples pass unmodified; there is no arithmetic and no sign handling.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_first`=0, `out_last`=0, `busy`=0.
  - `win_ready`=1.
  - Both buffers cleared, state IDLE.
- Reset mid-stream: both windows are discarded immediately and `out_valid` drops asynchronously. No partial window resumes after reset.
- Latency: window accepted at edge N → `out_valid`=1 with the first sample (`out_first`=1) after edge N.
- Throughput: with `out_ready` held at 1, one sample per cycle. A full window drains in `WINDOW_SIZE` cycles.
- Back-to-back windows: the last sample of window A and the first sample of window B appear on consecutive cycles, with zero bubbles.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_idx`, `out_first` and `out_last` hold stable.
- `out_valid` never drops mid-window except on reset.
- `win_data` is captured only on the accept edge. Later changes to `win_data` do not affect stored windows.

## Test plan
- Basic drain:
  - Stimulus: reset, then accept window `win_data[i]=i+1`, `out_ready`=1.
  - Required: `out_data` 1..32 on consecutive cycles; `out_first` on sample 1, `out_last` on sample 32; `out_valid` and `busy` fall after the 32nd transfer.
- Reverse order:
  - Stimulus: same window with `win_reverse`=1.
  - Required: `out_data` 32..1, `out_idx` 31..0.
- Backpressure:
  - Stimulus: toggle `out_ready` pseudo-randomly.
  - Required: output stays stable during stalls; all 32 samples are emitted exactly once, in order.
- Double buffering:
  - Stimulus: offer window A (values 0x100+i), then window B (0x200+i) while A streams, then window C.
  - Required: B is accepted; C sees `win_ready`=0 until A's last transfer; B's first sample follows A's last with no gap; C is accepted on the following cycle.
- Same-cycle accept:
  - Stimulus: with pending empty, offer a window on the cycle of A's final transfer.
  - Required: the window is accepted and its first sample appears the next cycle.
- Mid-stream reset:
  - Stimulus: assert `rst_n`=0 at sample 10 with a pending window loaded.
  - Required: all outputs go to their reset values; after release, no sample from either discarded window is emitted.

Source files
------------

// File: rtl/window_serializer.sv
// Parallel-to-stream window converter: a whole window is loaded in one handshake
// and emitted one sample per transfer, with a pending slot so windows stream back-to-back.
module window_serializer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WINDOW_SIZE = 32,
    parameter int unsigned IDX_W       = $clog2(WINDOW_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              win_valid,
    output logic              win_ready,
    input  logic [DATA_W-1:0] win_data [WINDOW_SIZE],
    input  logic              win_reverse,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WINDOW_SIZE - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_act  [WINDOW_SIZE];
    logic [DATA_W-1:0] r_pend [WINDOW_SIZE];
    logic              r_act_rev;
    logic              r_pend_rev;
    logic              r_pend_full;
    logic [IDX_W-1:0]  r_pos;

    logic              w_xfer;
    logic              w_done;
    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;

    // Handshake decode; win_ready depends on registers only.
    assign win_ready = !r_pend_full;
    assign w_accept  = win_valid && !r_pend_full;
    assign w_xfer    = out_valid && out_ready;
    assign w_done    = w_xfer && (r_pos == LAST_POS);
    assign w_idx     = r_act_rev ? (LAST_POS - r_pos) : r_pos;

    // Output views of the active slot; all are decodes of registered state.
    assign out_valid = (r_state == S_STREAM);
    assign out_idx   = w_idx;
    assign out_data  = r_act[w_idx];
    assign out_first = out_valid && (r_pos == '0);
    assign out_last  = out_valid && (r_pos == LAST_POS);
    assign busy      = out_valid || r_pend_full;

    // Slot management: load active when free (or freeing this cycle), else pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_act       <= '{default: '0};
            r_pend      <= '{default: '0};
            r_act_rev   <= 1'b0;
            r_pend_rev  <= 1'b0;
            r_pend_full <= 1'b0;
            r_pos       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_act     <= win_data;
                        r_act_rev <= win_reverse;
                        r_pos     <= '0;
                        r_state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_done) begin
                        r_pos <= '0;
                        if (r_pend_full) begin
                            r_act       <= r_pend;
                            r_act_rev   <= r_pend_rev;
                            r_pend_full <= 1'b0;
                        end else if (w_accept) begin
                            r_act     <= win_data;
                            r_act_rev <= win_reverse;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_pos <= r_pos + IDX_W'(1);
                        end
                        if (w_accept) begin
                            r_pend      <= win_data;
                            r_pend_rev  <= win_reverse;
                            r_pend_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_serializer.sv
// Randomized bench for window_serializer: a queue-of-samples model predicts every
// output cycle by cycle, with literal expectations at the directed scenario points.
module tb_window_serializer;

    localparam int DW = 16;
    localparam int WS = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          win_valid = 1'b0;
    logic          win_ready;
    logic [DW-1:0] win_data [WS];
    logic          win_reverse = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_first;
    logic          out_last;
    logic          busy;

    window_serializer #(.DATA_W(DW), .WINDOW_SIZE(WS), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .win_reverse (win_reverse),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_first   (out_first),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: the stream is just the concatenation of accepted windows' samples;
    // at most two windows may be held (the one draining plus one waiting).
    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        bit            first;
        bit            last;
    } samp_t;

    samp_t         q[$];
    logic [DW-1:0] log_d[$];
    int            nwin = 0;
    bit            pristine = 1'b1;
    bit            chk_en = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_window();
        samp_t s;
        for (int k = 0; k < WS; k++) begin
            s.idx   = win_reverse ? (WS - 1 - k) : k;
            s.d     = win_data[s.idx];
            s.first = (k == 0);
            s.last  = (k == WS - 1);
            q.push_back(s);
        end
    endtask

    task automatic model_step();
        bit    acc;
        bit    xfer;
        samp_t s;
        if (!rst_n) return;
        acc  = win_valid && (nwin < 2);
        xfer = (q.size() > 0) && out_ready;
        if (xfer) begin
            s = q.pop_front();
            log_d.push_back(s.d);
            if (s.last) nwin--;
        end
        if (acc) begin
            push_window();
            nwin++;
            pristine = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        log_d.delete();
        nwin     = 0;
        pristine = 1'b1;
    endtask

    task automatic set_window(input int base, input bit rev);
        for (int i = 0; i < WS; i++) win_data[i] = DW'(base + i);
        win_reverse = rev;
    endtask

    task automatic rand_window();
        for (int i = 0; i < WS; i++) win_data[i] = DW'($urandom);
        win_reverse = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name, input bit rand_ready);
        for (int i = 0; i < 3000 && q.size() > 0; i++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        out_ready = 1'b1;
        check(name, q.size(), 0);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("win_ready", win_ready, nwin < 2);
            check("busy", busy, nwin > 0);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("out_data", out_data, q[0].d);
                check("out_idx", out_idx, q[0].idx);
                check("out_first", out_first, q[0].first);
                check("out_last", out_last, q[0].last);
            end else begin
                check("idle_first", out_first, 0);
                check("idle_last", out_last, 0);
                if (pristine) begin
                    check("clear_data", out_data, 0);
                    check("clear_idx", out_idx, 0);
                end
            end
        end
    end

    initial begin
        set_window(0, 1'b0);
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_win_ready", win_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        step();

        // Basic drain, forward order
        log_d.delete();
        set_window(1, 1'b0);
        out_ready = 1'b1;
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        check("basic_first_data", out_data, 1);
        check("basic_first_flag", out_first, 1);
        check("basic_first_idx", out_idx, 0);
        repeat (31) step();
        check("basic_last_data", out_data, 32);
        check("basic_last_flag", out_last, 1);
        step();
        check("basic_done_valid", out_valid, 0);
        check("basic_done_busy", busy, 0);
        check("model_log_len", log_d.size(), 32);
        check("model_log_0", log_d[0], 1);
        check("model_log_31", log_d[31], 32);

        // Reverse order
        set_window(1, 1'b1);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        win_reverse = 1'b0;
        check("rev_first_data", out_data, 32);
        check("rev_first_idx", out_idx, 31);
        repeat (31) step();
        check("rev_last_data", out_data, 1);
        check("rev_last_idx", out_idx, 0);
        check("rev_last_flag", out_last, 1);
        step();
        check("rev_done_valid", out_valid, 0);

        // Backpressure with random ready
        rand_window();
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        drain("bp_drain", 1'b1);

        // Double buffering: A streams, B pends, C waits for A's last transfer
        out_ready = 1'b1;
        set_window(16'h100, 1'b0);
        win_valid = 1'b1;
        step();
        set_window(16'h200, 1'b0);
        step();
        set_window(16'h300, 1'b0);
        check("dbl_pend_full", win_ready, 0);
        for (int i = 0; i < 30; i++) begin
            step();
            check("dbl_c_blocked", win_ready, 0);
        end
        step();
        check("dbl_b_first_data", out_data, 16'h200);
        check("dbl_b_first_flag", out_first, 1);
        check("dbl_ready_after_promote", win_ready, 1);
        step();
        win_valid = 1'b0;
        check("dbl_c_accepted", win_ready, 0);
        check("dbl_b_second", out_data, 16'h201);
        drain("dbl_drain", 1'b0);

        // Same-cycle accept on A's final transfer
        set_window(16'h400, 1'b0);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        repeat (31) step();
        check("same_last_shown", out_last, 1);
        set_window(16'h500, 1'b0);
        win_valid = 1'b1;
        step();
        win_valid = 1'b0;
        check("same_next_data", out_data, 16'h500);
        check("same_next_first", out_first, 1);
        check("same_next_valid", out_valid, 1);
        drain("same_drain", 1'b0);

        // Mid-stream reset with a pending window loaded
        set_window(16'h600, 1'b0);
        win_valid = 1'b1;
        step();
        set_window(16'h700, 1'b1);
        step();
        win_valid = 1'b0;
        repeat (8) step();
        check("mid_sample10", out_data, 16'h609);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", win_ready, 1);
        check("mid_rst_data", out_data, 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (40) step();
        check("mid_no_resume", out_valid, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            win_valid = ($urandom_range(0, 3) == 0);
            if (win_valid) rand_window();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        win_valid = 1'b0;
        drain("rand_drain", 1'b1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
